imem_loader: RTL
================

Name: imem_loader

Overview:
- Writer-side counterpart of the instruction memory. It receives a byte stream from a host link such as a UART receiver or test harness.
- It assembles the bytes into 32-bit instruction words and writes them sequentially into the instruction memory's write port, starting at word address 0.
- It holds the CPU in reset while loading and reports done or error when the load finishes.

Parameters:
- DEPTH, 1024, number of 32-bit words in instruction memory.
- CNT_W, 11, width of the word counter and length field. Must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- in_valid  input  1  in_data holds a byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts in_data this cycle. A byte transfers when in_valid and in_ready are both 1.
- mem_we  output  1  instruction memory write enable, one cycle per word.
- mem_addr  output  32  word address (index, not byte address). Zero-extended from the counter.
- mem_wdata  output  32  instruction word to write.
- cpu_hold  output  1  hold the CPU and PC in reset.
- busy  output  1  load in progress.
- done  output  1  level; last load completed.
- err  output  1  level; last load rejected.
- words_loaded  output  CNT_W  number of words written in the current or last load.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0: in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, err, words_loaded.
  - The byte counter and the partial word are cleared.
  - Memory contents are not touched.
- States: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERR.
- IDLE / DONE / ERR:
  - in_ready=0.
  - A start pulse moves to LEN_HI, clears done, err and words_loaded, and sets cpu_hold=1 and busy=1 on the next cycle.
  - start is ignored in all other states.
- LEN_HI / LEN_LO:
  - in_ready=1.
  - The accepted bytes form the 16-bit word count N, most significant byte first.
  - Only the low CNT_W bits of N are used after the range check.
- After LEN_LO is accepted:
  - N==0: go to DONE (no writes).
  - N>DEPTH: go to ERR (no writes).
  - Otherwise: go to DATA.
- DATA:
  - in_ready=1.
  - Bytes are packed most significant byte first: first byte goes to bits [31:24], fourth byte to bits [7:0].
  - A 2-bit byte counter wraps 3->0.
  - Acceptance of the 4th byte moves the FSM to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=words_loaded (pre-increment value), mem_wdata=assembled word, in_ready=0.
  - Next cycle: words_loaded increments, mem_we returns to 0.
  - If the new words_loaded==N, go to DONE; otherwise go to DATA.
- DONE:
  - done=1, busy=0, cpu_hold=0 from the cycle DONE is entered.
- ERR:
  - err=1, busy=0, cpu_hold stays 1 so the CPU cannot run a partial or invalid image.
- Write throughput:
  - Minimum 5 cycles per word (4 accept cycles plus 1 WRITE cycle).
  - in_valid gaps only stall the FSM; no timeout.
- mem_addr / mem_wdata hold their last values outside WRITE.
- Reset mid-load:
  - Immediate return to IDLE and the partial word is discarded.
  - Words already written remain in memory; the host must reload.
- Bytes presented while in_ready=0 are not consumed. The source must hold them.

Test Plan:
- Two-word load:
  - Stimulus: start, then bytes 00 02 00 00 08 20 00 00 10 20 with in_valid held high.
  - Required: writes addr0=0x00000820, then addr1=0x00001020, one cycle each.
  - Then done=1, cpu_hold=0, words_loaded=2; the second write occurs 5 cycles after the first.
- Zero length:
  - Stimulus: start, bytes 00 00.
  - Required: no mem_we, done=1, words_loaded=0, cpu_hold returns to 0.
- Oversize:
  - Stimulus: start, bytes 04 01 (N=1025, DEPTH=1024).
  - Required: err=1, cpu_hold=1, no mem_we.
  - A subsequent start clears err and re-enters LEN_HI.
- Backpressure:
  - Stimulus: one-word load 00 01 20 09 00 64 with random in_valid gaps of 0-7 cycles.
  - Required: single write addr0=0x20090064.
  - in_ready=0 exactly during the WRITE cycle and after DONE.
- Reset mid-word:
  - Stimulus: assert rst_n=0 after 2 data bytes, then release and run a new one-word load AC 01 00 01.
  - Required: all outputs are 0 during reset.
  - The new load writes addr0=0xAC010001; no stale bytes appear in it.
- Start while busy:
  - Stimulus: pulse start during DATA.
  - Required: ignored; the load completes normally with the same N and the same word addresses.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the instruction memory: takes a 16-bit word count and then
// big-endian 32-bit words, and writes them to consecutive word addresses from 0.
module imem_loader #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded,
    output logic [2:0]       dbg_state
);

    // Handshake: a byte moves on a rising edge where in_valid and in_ready are both 1.
    // in_ready depends only on the state, never on in_valid.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t           state_q, state_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] wl_q, wl_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [23:0]      part_q, part_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;

    logic             xfer;
    logic [15:0]      len_full;
    logic [CNT_W-1:0] wl_inc;

    assign xfer     = in_valid & in_ready;
    assign len_full = {len_hi_q, in_data};
    assign wl_inc   = wl_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        wl_d     = wl_q;
        bcnt_d   = bcnt_q;
        part_d   = part_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        in_ready = 1'b0;
        mem_we   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    wl_d    = '0;
                    bcnt_d  = '0;
                    part_d  = '0;
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (xfer) begin
                    len_hi_d = in_data;
                    state_d  = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    // Range check uses the full 16-bit count; only the low bits are kept.
                    if (len_full == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_full} > DEPTH_L) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = CNT_W'(len_full);
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (xfer) begin
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        wdata_d = {part_q, in_data};
                        addr_d  = 32'(wl_q);
                        state_d = S_WRITE;
                    end else begin
                        part_d = {part_q[15:0], in_data};
                    end
                end
            end
            S_WRITE: begin
                mem_we = 1'b1;
                wl_d   = wl_inc;
                state_d = (wl_inc == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            wl_q     <= '0;
            bcnt_q   <= '0;
            part_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            wl_q     <= wl_d;
            bcnt_q   <= bcnt_d;
            part_q   <= part_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    // The CPU stays held in ERR so a rejected image can never run.
    assign busy         = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                          (state_q == S_DATA)   || (state_q == S_WRITE);
    assign cpu_hold     = busy || (state_q == S_ERR);
    assign done         = (state_q == S_DONE);
    assign err          = (state_q == S_ERR);
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign words_loaded = wl_q;
    assign dbg_state    = state_q;

endmodule
